// File: rtl/image_streaming_sender_pkg.sv
// Shared protocol constants and state encodings for the
// UART frame-buffer upload/readback paths.
package image_streaming_pkg;

  localparam logic [7:0] ACK      = 8'hAA;
  localparam logic [7:0] READ_REQ = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_SEND_BYTE,
    ST_WAIT_ACK,
    ST_ENDING,
    ST_ABORT
  } state_e;

  function automatic logic [31:0] frame_size(
    input int x,
    input int y
  );
    return 32'(x * y * 2);
  endfunction

endpackage

// File: rtl/image_streaming_sender_uart_tx_handshake.sv
// tx_ready/tx_busy request-release sequencer; done marks
// the cycle the transmitter has taken the byte.
module uart_tx_handshake (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done
);

  logic       tx_ready_q, tx_ready_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    tx_ready_d = tx_ready_q;
    tx_data_d  = tx_data_q;
    if (tx_ready_q && tx_busy) begin
      tx_ready_d = 1'b0;
    end else if (send && !tx_ready_q && !tx_busy) begin
      tx_ready_d = 1'b1;
      tx_data_d  = tx_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_ready_q <= tx_ready_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign tx_data  = tx_data_q;
  assign done     = tx_ready_q && tx_busy;

endmodule

// File: rtl/image_streaming_sender.sv
// Streams the frame buffer back to the host over UART,
// one host-acknowledged byte at a time.
module image_streaming_sender
  import image_streaming_pkg::*;
#(
  parameter int unsigned IMAGE_BUF_X = 1,
  parameter int unsigned IMAGE_BUF_Y = 1,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned ACK_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_ready,
  input  logic [7:0]  mem_out,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic        streaming_ended,
  output logic        streaming_error
);

  localparam int TW = (ACK_TIMEOUT > 0) ?
                      $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRIES > 0) ?
                      $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [31:0] LAST =
    frame_size(IMAGE_BUF_X, IMAGE_BUF_Y) - 32'd1;
  localparam logic [TW-1:0] TO_MAX = TW'(ACK_TIMEOUT);
  localparam logic [RW-1:0] RT_MAX = RW'(MAX_RETRIES);

  state_e          state_q, state_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            mem_rd_en_q, mem_rd_en_d;
  logic            busy_q, busy_d;
  logic            ended_q, ended_d;
  logic            error_q, error_d;
  logic [7:0]      byte_q, byte_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   to_q, to_d;

  logic            hs_send;
  logic [7:0]      hs_byte;
  logic            hs_done;
  logic            rx_ack;
  logic            rx_nak;
  logic            to_hit;

  assign rx_ack  = rx_ready && (rx_data == ACK);
  assign rx_nak  = rx_ready && (rx_data != ACK);
  assign to_hit  = (ACK_TIMEOUT != 0) && (to_q == TO_MAX);
  assign hs_send = (state_q == ST_SEND_HDR) ||
                   (state_q == ST_SEND_BYTE);
  assign hs_byte = (state_q == ST_SEND_HDR) ? ACK : byte_q;

  uart_tx_handshake u_tx_hs (
    .clk     (clk),
    .reset_n (reset_n),
    .send    (hs_send),
    .tx_byte (hs_byte),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .done    (hs_done)
  );

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    byte_d     = byte_q;
    retry_d    = retry_q;
    to_d       = to_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready && rx_data == READ_REQ) begin
          mem_addr_d = 32'd0;
          state_d    = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        if (hs_done) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        byte_d  = mem_out;
        retry_d = '0;
        to_d    = '0;
        state_d = ST_SEND_BYTE;
      end
      ST_SEND_BYTE: begin
        if (hs_done) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        to_d = to_q + TW'(1);
        // a received byte wins over a same-cycle timeout
        if (rx_ack) begin
          if (mem_addr_q == LAST) begin
            state_d = ST_ENDING;
          end else begin
            mem_addr_d = mem_addr_q + 32'd1;
            state_d    = ST_FETCH;
          end
        end else if (rx_nak || to_hit) begin
          if (retry_q == RT_MAX) begin
            state_d = ST_ABORT;
          end else begin
            retry_d = retry_q + RW'(1);
            to_d    = '0;
            state_d = ST_SEND_BYTE;
          end
        end
      end
      ST_ENDING: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    mem_rd_en_d = (state_d == ST_FETCH);
    ended_d     = (state_d == ST_ENDING);
    error_d     = (state_d == ST_ABORT);
    busy_d      = !(state_d inside
                    {ST_IDLE, ST_ENDING, ST_ABORT});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= 32'd0;
      mem_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
      ended_q     <= 1'b0;
      error_q     <= 1'b0;
      byte_q      <= 8'h00;
      retry_q     <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      busy_q      <= busy_d;
      ended_q     <= ended_d;
      error_q     <= error_d;
      byte_q      <= byte_d;
      retry_q     <= retry_d;
      to_q        <= to_d;
    end
  end

  assign mem_addr        = mem_addr_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign busy            = busy_q;
  assign streaming_ended = ended_q;
  assign streaming_error = error_q;

endmodule

// File: tb/tb_image_streaming_sender.sv
// Directed bench: host, UART tx core and frame memory
// models around a 2x2 image_streaming_sender.
module tb_image_streaming_sender;
  import image_streaming_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [7:0]  mem_out = 8'h00;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        busy;
  logic        streaming_ended;
  logic        streaming_error;

  image_streaming_sender #(
    .IMAGE_BUF_X(2),
    .IMAGE_BUF_Y(2),
    .MAX_RETRIES(3),
    .ACK_TIMEOUT(50)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_busy        (tx_busy),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .mem_out        (mem_out),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .busy           (busy),
    .streaming_ended(streaming_ended),
    .streaming_error(streaming_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // frame memory holds byte i at address i
  always @(posedge clk)
    if (mem_rd_en) mem_out <= 8'(mem_addr);

  int          cyc = 0;
  int          acc_cnt = 0;
  int          busy_cnt = 0;
  int          accept_delay = 0;
  logic [7:0]  txlog[$];
  int          txcyc[$];
  logic [31:0] rdlog[$];
  int          ended_cnt = 0;
  int          error_cnt = 0;
  int          tx_idx = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) rdlog.push_back(mem_addr);
    if (streaming_ended) ended_cnt <= ended_cnt + 1;
    if (streaming_error) error_cnt <= error_cnt + 1;
  end

  // UART tx core: optional start delay, then 4 busy cycles
  always @(posedge clk) begin
    if (!tx_busy) begin
      if (tx_ready) begin
        if (acc_cnt >= accept_delay) begin
          txlog.push_back(tx_data);
          txcyc.push_back(cyc);
          tx_busy  <= 1'b1;
          busy_cnt <= 3;
          acc_cnt  <= 0;
        end else begin
          acc_cnt <= acc_cnt + 1;
        end
      end
    end else if (busy_cnt == 0) begin
      tx_busy <= 1'b0;
    end else begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clr();
    txlog.delete();
    txcyc.delete();
    rdlog.delete();
    tx_idx = 0;
  endtask

  task automatic wait_tx(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'hFF;
    while (txlog.size() <= tx_idx && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (txlog.size() <= tx_idx) begin
      chk("tx_wait", txlog.size(), tx_idx + 1);
      return;
    end
    b = txlog[tx_idx];
    tx_idx++;
    n = 0;
    while (tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ended(input int e0);
    int n;
    n = 0;
    while (ended_cnt == e0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ended", ended_cnt - e0, 1);
  endtask

  task automatic xfer(input int nak_at,
                      input int naks,
                      input int stop_at);
    logic [7:0] b;
    int e0;
    int reps;
    e0 = ended_cnt;
    send_rx(READ_REQ);
    wait_tx(b);
    chk("hdr", b, 8'hAA);
    for (int i = 0; i < 8; i++) begin
      reps = (i == nak_at) ? naks : 0;
      for (int k = 0; k <= reps; k++) begin
        wait_tx(b);
        chk($sformatf("byte%0d", i), b, 8'(i));
        if (i == stop_at) return;
        send_rx(k < reps ? 8'h00 : 8'hAA);
      end
    end
    wait_ended(e0);
  endtask

  function automatic logic [63:0] outs();
    return {tx_data, tx_ready, mem_rd_en, mem_addr,
            busy, streaming_ended, streaming_error};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int e0, r0, n, hi, bad, cnt;
    logic [7:0] d0;

    repeat (3) @(negedge clk);
    chk("rst_outs", outs(), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // full frame, every byte acknowledged
    clr();
    xfer(-1, 0, -1);
    chk("t1_ntx", txlog.size(), 9);
    chk("t1_nrd", rdlog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < rdlog.size())
        chk($sformatf("t1_rd%0d", i), rdlog[i], i);
    chk("t1_busy", busy, 0);

    // wrong request byte is ignored
    clr();
    hi = 0;
    send_rx(8'h41);
    repeat (20) begin
      @(negedge clk);
      if (busy || tx_ready) hi++;
    end
    chk("t2_ntx", txlog.size(), 0);
    chk("t2_busy", hi, 0);

    // two NAKs on byte 3, then ACK
    clr();
    xfer(3, 2, -1);
    cnt = 0;
    foreach (txlog[i]) if (txlog[i] == 8'h03) cnt++;
    chk("t3_tx3", cnt, 3);
    cnt = 0;
    foreach (rdlog[i]) if (rdlog[i] == 32'd3) cnt++;
    chk("t3_rd3", cnt, 1);
    chk("t3_ntx", txlog.size(), 11);

    // host silent on byte 0: 4 sends then abort
    clr();
    e0 = ended_cnt;
    r0 = error_cnt;
    send_rx(READ_REQ);
    wait_tx(b);
    chk("t4_hdr", b, 8'hAA);
    for (int k = 0; k < 4; k++) begin
      wait_tx(b);
      chk($sformatf("t4_tx%0d", k), b, 8'h00);
    end
    for (int k = 2; k < 5; k++)
      if (k < txcyc.size())
        chk($sformatf("t4_gap%0d", k),
            (txcyc[k] - txcyc[k-1]) >= 50, 1);
    n = 0;
    while (error_cnt == r0 && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk("t4_err", error_cnt - r0, 1);
    chk("t4_addr", mem_addr, 0);
    chk("t4_busy", busy, 0);
    repeat (60) @(negedge clk);
    chk("t4_ntx", txlog.size(), 5);
    chk("t4_noend", ended_cnt - e0, 0);

    // tx core slow to start: tx_ready held, data stable
    clr();
    e0 = ended_cnt;
    send_rx(READ_REQ);
    wait_tx(b);
    wait_tx(b);
    chk("t5_b0", b, 8'h00);
    accept_delay = 20;
    send_rx(8'hAA);
    n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    d0 = tx_data;
    chk("t5_data", d0, 8'h01);
    hi = 0;
    bad = 0;
    n = 0;
    while (!tx_busy && n < 100) begin
      if (!tx_ready || tx_data != d0) bad++;
      hi++;
      @(negedge clk);
      n++;
    end
    accept_delay = 0;
    chk("t5_hold", hi >= 20, 1);
    chk("t5_stable", bad, 0);
    chk("t5_rdy_busy", tx_ready, 1);
    @(negedge clk);
    chk("t5_release", tx_ready, 0);
    for (int i = 1; i < 8; i++) begin
      wait_tx(b);
      chk($sformatf("t5_byte%0d", i), b, 8'(i));
      send_rx(8'hAA);
    end
    wait_ended(e0);

    // async reset during WAIT_ACK of byte 5
    clr();
    xfer(-1, 0, 5);
    e0 = ended_cnt;
    r0 = error_cnt;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async", outs(), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_held", outs(), 64'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_nopulse", (ended_cnt - e0) + (error_cnt - r0), 0);
    clr();
    xfer(-1, 0, -1);
    chk("t6_nrd", rdlog.size(), 8);
    if (rdlog.size() > 0) chk("t6_rd0", rdlog[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
